// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table shared with the hex-to-segment encoder, digit count and an-select helper.
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    typedef logic [6:0] seg_t;
    localparam seg_t GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [1:0] an_index(input logic [NUM_DIGITS-1:0] an);
        an_index = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) an_index = 2'(i);
    endfunction
endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: display-snoop inputs and captured-value outputs; SEG7_CAPTURE_DP_EN adds dp/dp_flags.
interface seg7_capture_if;
    import seg7_pkg::*;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    bad_pattern;
    logic [1:0]              bad_digit;
`ifdef SEG7_CAPTURE_DP_EN
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dp_flags;
    modport master (output an, seg, clear, dp,
                    input  digits, digit_valid, frame_valid, bad_pattern, bad_digit, dp_flags);
    modport slave  (input  an, seg, clear, dp,
                    output digits, digit_valid, frame_valid, bad_pattern, bad_digit, dp_flags);
`else
    modport master (output an, seg, clear,
                    input  digits, digit_valid, frame_valid, bad_pattern, bad_digit);
    modport slave  (input  an, seg, clear,
                    output digits, digit_valid, frame_valid, bad_pattern, bad_digit);
`endif
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: inverse glyph lookup, segment pattern to hex nibble with hit flag.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_nibble,
    output logic       o_hit
);
    always_comb begin
        o_nibble = 4'd0;
        o_hit    = 1'b0;
        for (int i = 0; i < 16; i++)
            if (i_seg == GLYPHS[i]) begin
                o_nibble = 4'(i);
                o_hit    = 1'b1;
            end
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: snoops a multiplexed 7-segment display and captures stable digits into a hex frame.
// Optional decimal-point capture under SEG7_CAPTURE_DP_EN.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    seg7_capture_if.slave bus
);
    logic [NUM_DIGITS-1:0]   r_an;
    seg_t                    r_seg;
    logic [7:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_frame;
    logic                    r_bad;
    logic [1:0]              r_bad_digit;
    logic                    w_same;
    logic                    w_hit;
    logic [3:0]              w_nibble;
    logic [1:0]              w_k;
    logic                    w_capture;
    logic [7:0]              w_cnt_next;
    logic [NUM_DIGITS-1:0]   w_valid_next;
`ifdef SEG7_CAPTURE_DP_EN
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dp_flags;
    assign w_same = {bus.dp, bus.an, bus.seg} == {r_dp, r_an, r_seg};
    assign bus.dp_flags = r_dp_flags;
`else
    assign w_same = {bus.an, bus.seg} == {r_an, r_seg};
`endif
    seg7_decode u_decode (
        .i_seg    (r_seg),
        .o_nibble (w_nibble),
        .o_hit    (w_hit)
    );
    // Counter reaches STABLE_CYCLES on the edge E0+STABLE_CYCLES, E0 being the edge that registered the new sample.
    assign w_k          = an_index(r_an);
    assign w_capture    = w_same && (r_cnt == 8'(STABLE_CYCLES - 1)) && ($countones(~r_an) == 1);
    assign w_cnt_next   = !w_same ? 8'd0 : (&r_cnt ? r_cnt : r_cnt + 8'd1);
    assign w_valid_next = ((&r_valid) ? '0 : r_valid) | ((w_capture && w_hit) ? (4'b0001 << w_k) : 4'b0000);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an        <= '1;
            r_seg       <= '0;
            r_cnt       <= '0;
            r_digits    <= '0;
            r_valid     <= '0;
            r_frame     <= 1'b0;
            r_bad       <= 1'b0;
            r_bad_digit <= '0;
`ifdef SEG7_CAPTURE_DP_EN
            r_dp        <= 1'b0;
            r_dp_flags  <= '0;
`endif
        end else begin
            r_an  <= bus.an;
            r_seg <= bus.seg;
`ifdef SEG7_CAPTURE_DP_EN
            r_dp  <= bus.dp;
`endif
            if (bus.clear) begin
                r_cnt       <= '0;
                r_digits    <= '0;
                r_valid     <= '0;
                r_frame     <= 1'b0;
                r_bad       <= 1'b0;
                r_bad_digit <= '0;
`ifdef SEG7_CAPTURE_DP_EN
                r_dp_flags  <= '0;
`endif
            end else begin
                r_cnt   <= w_cnt_next;
                r_frame <= &r_valid;
                r_valid <= w_valid_next;
                if (w_capture && w_hit) begin
                    r_digits[{w_k, 2'b00} +: 4] <= w_nibble;
`ifdef SEG7_CAPTURE_DP_EN
                    r_dp_flags[w_k] <= r_dp;
`endif
                end
                if (w_capture && !w_hit) begin
                    r_bad       <= 1'b1;
                    r_bad_digit <= w_k;
                end
            end
        end
    end
    assign bus.digits      = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.frame_valid = r_frame;
    assign bus.bad_pattern = r_bad;
    assign bus.bad_digit   = r_bad_digit;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed vectors for seg7_capture with STABLE_CYCLES=4; inputs driven and outputs sampled on negedge.
module tb_seg7_capture;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   frame_cnt = 0;
    seg7_capture_if bus ();
    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #2;
        if (bus.frame_valid) frame_cnt++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an  = an;
        bus.seg = seg;
        tick(n);
    endtask
    task automatic do_clear();
        bus.an    = 4'hF;
        bus.seg   = 7'h00;
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask
    initial begin
        bus.an    = 4'hF;
        bus.seg   = 7'h00;
        bus.clear = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
        bus.dp    = 1'b0;
`endif
        tick(3);
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_frame", 32'(bus.frame_valid), 32'h0);
        check("rst_bad", 32'(bus.bad_pattern), 32'h0);
        check("rst_bad_digit", 32'(bus.bad_digit), 32'h0);
`ifdef SEG7_CAPTURE_DP_EN
        check("rst_dp_flags", 32'(bus.dp_flags), 32'h0);
`endif
        reset = 1'b1;
        tick(2);
        // single digit: capture lands exactly four edges after the first register edge
        hold(4'b1110, 7'h4F, 4);
        check("dwell_early", 32'(bus.digit_valid), 32'h0);
        hold(4'b1110, 7'h4F, 1);
        check("dwell_valid", 32'(bus.digit_valid), 32'h1);
        check("dwell_nibble", 32'(bus.digits[3:0]), 32'h3);
        tick(1);
        check("dwell_once", 32'(bus.digit_valid), 32'h1);
        do_clear();
        check("clear_digits", 32'(bus.digits), 32'h0);
        // full frame
        hold(4'b1110, 7'h06, 5);
        hold(4'b1101, 7'h5B, 5);
        hold(4'b1011, 7'h4F, 5);
        hold(4'b0111, 7'h66, 5);
        check("frame_digits", 32'(bus.digits), 32'h4321);
        check("frame_all_valid", 32'(bus.digit_valid), 32'hF);
        check("frame_not_yet", 32'(frame_cnt), 32'd0);
        hold(4'hF, 7'h00, 1);
        check("frame_pulse", 32'(bus.frame_valid), 32'h1);
        check("frame_valid_cleared", 32'(bus.digit_valid), 32'h0);
        tick(1);
        check("frame_one_cycle", 32'(bus.frame_valid), 32'h0);
        check("frame_count", 32'(frame_cnt), 32'd1);
        check("frame_retained", 32'(bus.digits), 32'h4321);
        // re-capture overwrites within a frame
        hold(4'b1110, 7'h77, 5);
        check("recap_a", 32'(bus.digits), 32'h432A);
        hold(4'b1110, 7'h7C, 5);
        check("recap_b", 32'(bus.digits), 32'h432B);
        check("recap_valid", 32'(bus.digit_valid), 32'h1);
        do_clear();
        // seg toggling faster than the dwell never captures
        for (int i = 0; i < 8; i++) hold(4'b1110, (i % 2) ? 7'h06 : 7'h3F, 3);
        hold(4'hF, 7'h00, 1);
        check("toggle_valid", 32'(bus.digit_valid), 32'h0);
        check("toggle_digits", 32'(bus.digits), 32'h0);
        // blank pattern on digit 2
        hold(4'b1011, 7'h00, 8);
        check("bad_flag", 32'(bus.bad_pattern), 32'h1);
        check("bad_index", 32'(bus.bad_digit), 32'h2);
        check("bad_digits", 32'(bus.digits), 32'h0);
        check("bad_valid", 32'(bus.digit_valid), 32'h0);
        hold(4'b1110, 7'h3F, 5);
        check("bad_sticky", 32'(bus.bad_pattern), 32'h1);
        check("bad_then_good", 32'(bus.digit_valid), 32'h1);
        do_clear();
        check("bad_cleared", 32'(bus.bad_pattern), 32'h0);
        // clear on the fourth capture edge wins
        hold(4'b1110, 7'h06, 5);
        hold(4'b1101, 7'h5B, 5);
        hold(4'b1011, 7'h4F, 5);
        hold(4'b0111, 7'h66, 4);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        bus.an    = 4'hF;
        check("clr4_frame", 32'(bus.frame_valid), 32'h0);
        check("clr4_digits", 32'(bus.digits), 32'h0);
        check("clr4_valid", 32'(bus.digit_valid), 32'h0);
        tick(2);
        check("clr4_no_pulse", 32'(frame_cnt), 32'd1);
        // reset mid-frame abandons partial capture
        hold(4'b1110, 7'h06, 5);
        hold(4'b1101, 7'h5B, 5);
        check("mid_valid", 32'(bus.digit_valid), 32'h3);
        hold(4'b1011, 7'h6D, 2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_valid", 32'(bus.digit_valid), 32'h0);
        reset = 1'b1;
        hold(4'b1011, 7'h6D, 5);
        hold(4'b0111, 7'h7D, 5);
        check("post_rst_valid", 32'(bus.digit_valid), 32'hC);
        check("post_rst_digits", 32'(bus.digits), 32'h6500);
        hold(4'hF, 7'h00, 3);
        check("post_rst_no_frame", 32'(frame_cnt), 32'd1);
        hold(4'b1110, 7'h06, 5);
        hold(4'b1101, 7'h5B, 5);
        hold(4'hF, 7'h00, 2);
        check("refill_frame", 32'(frame_cnt), 32'd2);
        check("refill_digits", 32'(bus.digits), 32'h6521);
        check("refill_valid", 32'(bus.digit_valid), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
